// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge engine.
// Holds the run-state encoding, kernel weights and width helpers.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam int K_EDGE     = 1;
  localparam int K_MID      = 2;
  localparam int GUARD_BITS = 3;
  localparam int FLUSH_CYC  = 3;

  function automatic int acc_width(input int w);
    return w + GUARD_BITS;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two row delays plus the 3x3 window; flags when the window
// covers a full neighbourhood inside the current image.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_pixel,
  output logic [2:0][2:0][WIDTH-1:0]  win,
  output logic                        win_valid
);

  localparam int CW = cnt_width(IMG_W);
  localparam int RW = cnt_width(IMG_H);

  logic [CW-1:0]             col;
  logic [RW-1:0]             row;
  logic [IMG_W-1:0][WIDTH-1:0] row1;
  logic [IMG_W-1:0][WIDTH-1:0] row2;
  logic                      col_last;
  logic                      row_last;

  assign col_last = col == CW'(IMG_W - 1);
  assign row_last = row == RW'(IMG_H - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
    end else if (flush) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= in_valid && (row >= RW'(2)) && (col >= CW'(2));
      if (in_valid) begin
        col <= col_last ? '0 : col + CW'(1);
        if (col_last)
          row <= row_last ? '0 : row + RW'(1);
      end
    end
  end

  // Row 0 of the window is the oldest image row, column 2 the newest pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row1 <= '0;
      row2 <= '0;
      win  <= '0;
    end else if (in_valid) begin
      row1 <= {row1[IMG_W-2:0], in_pixel};
      row2 <= {row2[IMG_W-2:0], row1[IMG_W-1]};
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= row2[IMG_W-1];
      win[1][2] <= row1[IMG_W-1];
      win[2][2] <= in_pixel;
    end
  end

endmodule

// File: rtl/sobel_engine.sv
// Streaming Sobel engine: A_RAM in, |Gx| and |Gy| out to GX/GY RAMs.
// Define SOBEL_THRESH_EN to binarise outputs against THRESHOLD.
module sobel_engine
  import sobel_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int IMG_W        = 128,
  parameter int IMG_H        = 128,
  parameter int A_DEPTH_BITS = 14,
  parameter int G_DEPTH_BITS = 14,
  parameter int THRESHOLD    = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    Start,
  output logic                    Done,
  output logic                    A_read_en,
  output logic [A_DEPTH_BITS-1:0] A_read_address,
  input  logic [WIDTH-1:0]        A_read_data_out,
  output logic                    GX_write_en,
  output logic                    GY_write_en,
  output logic [G_DEPTH_BITS-1:0] GX_write_address,
  output logic [G_DEPTH_BITS-1:0] GY_write_address,
  output logic [WIDTH-1:0]        GX_write_data_in,
  output logic [WIDTH-1:0]        GY_write_data_in
);

  localparam int ACC = acc_width(WIDTH);
  localparam int N   = IMG_W * IMG_H;
  localparam logic [WIDTH-1:0] PIX_MAX = '1;
`ifdef SOBEL_THRESH_EN
  localparam bit THRESH_ON = 1'b1;
`else
  localparam bit THRESH_ON = 1'b0;
`endif

  state_t                    state;
  state_t                    state_next;
  logic [1:0]                flush_cnt;
  logic [A_DEPTH_BITS-1:0]   addr;
  logic [G_DEPTH_BITS-1:0]   out_idx;
  logic                      flush;
  logic                      rd_valid;
  logic                      win_valid;
  logic [2:0][2:0][WIDTH-1:0] win;
  logic signed [ACC-1:0]     gx;
  logic signed [ACC-1:0]     gy;

  function automatic logic signed [ACC-1:0] ext(input logic [WIDTH-1:0] p);
    return $signed({{GUARD_BITS{1'b0}}, p});
  endfunction

  function automatic logic signed [ACC-1:0] col_sum(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c
  );
    return ext(a) * ACC'(K_EDGE) + ext(b) * ACC'(K_MID) + ext(c) * ACC'(K_EDGE);
  endfunction

  // Absolute value first, then clamp, then optional binarisation.
  function automatic logic [WIDTH-1:0] mag(input logic signed [ACC-1:0] g);
    logic [ACC-1:0]   a;
    logic [WIDTH-1:0] s;
    a = g[ACC-1] ? ACC'(-g) : ACC'(g);
    s = (a > ACC'(PIX_MAX)) ? PIX_MAX : a[WIDTH-1:0];
    if (THRESH_ON)
      s = (s >= WIDTH'(THRESHOLD)) ? PIX_MAX : '0;
    return s;
  endfunction

  assign A_read_en      = state == RUN;
  assign A_read_address = addr;
  assign Done           = state == DONE;
  assign flush          = !Start || !(state inside {RUN, FLUSH});

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (!Start) state_next = IDLE;
               else if (addr == A_DEPTH_BITS'(N - 1)) state_next = FLUSH;
      FLUSH:   if (!Start) state_next = IDLE;
               else if (flush_cnt == 2'(FLUSH_CYC - 1)) state_next = DONE;
      DONE:    if (!Start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      addr      <= '0;
      flush_cnt <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state     <= state_next;
      addr      <= (state == RUN && state_next == RUN) ? addr + A_DEPTH_BITS'(1) : '0;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : '0;
      rd_valid  <= A_read_en && !flush;
    end
  end

  sobel_line_buffer #(
    .WIDTH (WIDTH),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_line_buffer (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (rd_valid),
    .in_pixel  (A_read_data_out),
    .win       (win),
    .win_valid (win_valid)
  );

  always_comb begin
    gx = col_sum(win[0][2], win[1][2], win[2][2])
       - col_sum(win[0][0], win[1][0], win[2][0]);
    gy = col_sum(win[2][0], win[2][1], win[2][2])
       - col_sum(win[0][0], win[0][1], win[0][2]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      GX_write_en      <= 1'b0;
      GY_write_en      <= 1'b0;
      GX_write_address <= '0;
      GY_write_address <= '0;
      GX_write_data_in <= '0;
      GY_write_data_in <= '0;
      out_idx          <= '0;
    end else if (flush) begin
      GX_write_en <= 1'b0;
      GY_write_en <= 1'b0;
      out_idx     <= '0;
    end else begin
      GX_write_en <= win_valid;
      GY_write_en <= win_valid;
      if (win_valid) begin
        GX_write_data_in <= mag(gx);
        GY_write_data_in <= mag(gy);
        GX_write_address <= out_idx;
        GY_write_address <= out_idx;
        out_idx          <= out_idx + G_DEPTH_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_sobel_engine.sv
// Scoreboard bench for sobel_engine on a 4x4 image.
// Directed images with hand-derived Gx/Gy; monitor pops per write.
module tb_sobel_engine;

  localparam int W   = 8;
  localparam int IW  = 4;
  localparam int IH  = 4;
  localparam int AD  = 4;
  localparam int GD  = 4;
  localparam int THR = 40;
  localparam int N   = IW * IH;
  localparam int M   = (IW - 2) * (IH - 2);

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          Start = 1'b0;
  logic          Done;
  logic          A_read_en;
  logic [AD-1:0] A_read_address;
  logic [W-1:0]  A_read_data_out = '0;
  logic          GX_write_en;
  logic          GY_write_en;
  logic [GD-1:0] GX_write_address;
  logic [GD-1:0] GY_write_address;
  logic [W-1:0]  GX_write_data_in;
  logic [W-1:0]  GY_write_data_in;

  sobel_engine #(
    .WIDTH        (W),
    .IMG_W        (IW),
    .IMG_H        (IH),
    .A_DEPTH_BITS (AD),
    .G_DEPTH_BITS (GD),
    .THRESHOLD    (THR)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .Start            (Start),
    .Done             (Done),
    .A_read_en        (A_read_en),
    .A_read_address   (A_read_address),
    .A_read_data_out  (A_read_data_out),
    .GX_write_en      (GX_write_en),
    .GY_write_en      (GY_write_en),
    .GX_write_address (GX_write_address),
    .GY_write_address (GY_write_address),
    .GX_write_data_in (GX_write_data_in),
    .GY_write_data_in (GY_write_data_in)
  );

  always #5 clk = ~clk;

  logic [W-1:0] img [N];

  always @(posedge clk)
    if (A_read_en) A_read_data_out <= img[A_read_address];

  typedef struct {
    logic [W-1:0]  gx;
    logic [W-1:0]  gy;
    logic [GD-1:0] addr;
  } exp_t;

  exp_t sbq[$];
  int compared = 0;
  int mismatched = 0;

  // Outputs in write order: centres (1,1), (1,2), (2,1), (2,2)
  int exp_gx [6][4] = '{
    '{0, 0, 0, 0},
    '{40, 40, 40, 40},
    '{40, 40, 40, 40},
    '{255, 255, 255, 255},
    '{16, 32, 16, 32},
    '{0, 0, 0, 0}
  };
  int exp_gy [6][4] = '{
    '{0, 0, 0, 0},
    '{0, 0, 0, 0},
    '{0, 0, 0, 0},
    '{0, 0, 0, 0},
    '{32, 32, 64, 64},
    '{255, 255, 255, 255}
  };

  function automatic logic [W-1:0] post(input int g);
`ifdef SOBEL_THRESH_EN
    return (g >= THR) ? 8'd255 : 8'd0;
`else
    return W'(g);
`endif
  endfunction

  function automatic logic [W-1:0] pix(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'd100;
      1:       return (c >= 2) ? 8'd10 : 8'd0;
      2:       return (c < 2) ? 8'd10 : 8'd0;
      3:       return (c >= 2) ? 8'd255 : 8'd0;
      4:       return W'(c * c + 2 * r * r);
      default: return (r < 2) ? 8'd255 : 8'd0;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && (GX_write_en || GY_write_en)) begin
      compared++;
      if (sbq.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: addr %0d gx %0d gy %0d, required no write",
                 GX_write_address, GX_write_data_in, GY_write_data_in);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (GX_write_en !== GY_write_en || GX_write_address !== e.addr ||
            GY_write_address !== e.addr || GX_write_data_in !== e.gx ||
            GY_write_data_in !== e.gy) begin
          mismatched++;
          $display("FAIL write: en %b/%b addr %0d/%0d gx %0d gy %0d, required addr %0d gx %0d gy %0d",
                   GX_write_en, GY_write_en, GX_write_address, GY_write_address,
                   GX_write_data_in, GY_write_data_in, e.addr, e.gx, e.gy);
        end
      end
    end
  end

  task automatic load(input int kind);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        img[r * IW + c] = pix(kind, r, c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_image(input int kind);
    int cyc;
    exp_t e;
    load(kind);
    for (int i = 0; i < M; i++) begin
      e.gx   = post(exp_gx[kind][i]);
      e.gy   = post(exp_gy[kind][i]);
      e.addr = GD'(i);
      sbq.push_back(e);
    end
    Start = 1'b1;
    cyc = 1;
    while (!Done && cyc < 200) begin
      step();
      cyc++;
    end
    check($sformatf("latency_k%0d", kind), cyc, 1 + N + 3 + 1);
    check($sformatf("drain_k%0d", kind), sbq.size(), 0);
    sbq.delete();
    repeat (3) step();
    check("done_hold", Done, 1);
    check("no_rerun", A_read_en, 0);
    Start = 1'b0;
    step();
    check("done_clear", Done, 0);
  endtask

  task automatic wait_addr(input int a);
    int n;
    n = 0;
    while (A_read_address != AD'(a) && n < 40) begin
      step();
      n++;
    end
    check("addr_reached", A_read_address, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    load(0);
    #1 resetn = 1'b0;
    repeat (3) step();
    check("rst_done", Done, 0);
    check("rst_rd_en", A_read_en, 0);
    check("rst_outs", {GX_write_en, GY_write_en, A_read_address, GX_write_address,
                       GY_write_address, GX_write_data_in, GY_write_data_in}, 0);
    resetn = 1'b1;
    step();

    for (int k = 0; k < 6; k++) begin
      run_image(k);
      step();
    end

    load(4);
    Start = 1'b1;
    wait_addr(12);
    Start = 1'b0;
    step();
    check("abort_rd_en", A_read_en, 0);
    check("abort_wr_en", GX_write_en | GY_write_en, 0);
    check("abort_done", Done, 0);
    repeat (8) step();
    check("abort_idle_done", Done, 0);
    run_image(4);
    step();

    Start = 1'b1;
    wait_addr(5);
    #2 resetn = 1'b0;
    #1;
    check("midrun_rst_rd_en", A_read_en, 0);
    check("midrun_rst_outs", {Done, GX_write_en, GY_write_en, A_read_address,
                              GX_write_address, GY_write_address,
                              GX_write_data_in, GY_write_data_in}, 0);
    Start = 1'b0;
    step();
    resetn = 1'b1;
    step();
    check("post_rst_idle", A_read_en, 0);
    run_image(3);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
